// File: rtl/hwpe_stream_sink_realign_line_pkg.sv
// Shared types for the per-line byte realigner: line descriptor, FSM state and default widths.
package hwpe_stream_sink_realign_line_pkg;

    localparam int REALIGN_DATA_WIDTH = 32;
    localparam int REALIGN_STRB_WIDTH = REALIGN_DATA_WIDTH / 8;
    localparam int REALIGN_OFF_WIDTH  = $clog2(REALIGN_STRB_WIDTH);
    localparam int REALIGN_LEN_WIDTH  = 16;

    typedef struct packed {
        logic [REALIGN_OFF_WIDTH-1:0] offset;
        logic [REALIGN_LEN_WIDTH-1:0] line_beats;
    } ctrl_line_realign_t;

    typedef enum logic [1:0] {
        RLN_IDLE,
        RLN_STREAM,
        RLN_FLUSH
    } realign_line_state_t;

endpackage

// File: rtl/hwpe_stream_sink_realign_line_if.sv
// Valid/ready byte stream with strobes; master drives the beat, slave returns ready.
interface hwpe_stream_sink_realign_line_if #(
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport master (output valid, output data, output strb, input ready);
    modport slave  (input valid, input data, input strb, output ready);
endinterface

// File: rtl/hwpe_stream_sink_realign_line_byte_shift.sv
// Combinational byte shifter: moves the new beat up by offset bytes and fills the low bytes
// with the spilled top bytes of the previous beat.
module hwpe_stream_sink_realign_line_byte_shift #(
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int OFF_WIDTH  = $clog2(STRB_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] new_data,
    input  logic [STRB_WIDTH-1:0] new_strb,
    input  logic [DATA_WIDTH-1:0] res_data,
    input  logic [STRB_WIDTH-1:0] res_strb,
    input  logic [OFF_WIDTH-1:0]  offset,
    input  logic                  use_res,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [STRB_WIDTH-1:0] out_strb
);
    logic [OFF_WIDTH:0]    rem;
    logic [DATA_WIDTH-1:0] head_data, tail_data;
    logic [STRB_WIDTH-1:0] head_strb, tail_strb;

    // With offset 0, rem equals the full word, so the tail shift clears the residue entirely.
    assign rem       = (OFF_WIDTH + 1)'(STRB_WIDTH) - {1'b0, offset};
    assign head_data = new_data << {offset, 3'b000};
    assign head_strb = new_strb << offset;
    assign tail_data = res_data >> {rem, 3'b000};
    assign tail_strb = res_strb >> rem;

    genvar gi;
    generate
        for (gi = 0; gi < STRB_WIDTH; gi++) begin : g_byte
            assign out_data[8*gi +: 8] = head_data[8*gi +: 8] | (use_res ? tail_data[8*gi +: 8] : 8'h00);
            assign out_strb[gi]        = head_strb[gi] | (use_res & tail_strb[gi]);
        end
    endgenerate
endmodule

// File: rtl/hwpe_stream_sink_realign_line.sv
// Per-line byte realigner with end-of-line flush beat.
// Optional output register: define HWPE_STREAM_SINK_REALIGN_SKID_EN.
module hwpe_stream_sink_realign_line
    import hwpe_stream_sink_realign_line_pkg::*;
#(
    parameter int DATA_WIDTH = REALIGN_DATA_WIDTH,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH  = REALIGN_LEN_WIDTH
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            clear_i,
    input  logic                            ctrl_valid_i,
    output logic                            ctrl_ready_o,
    input  ctrl_line_realign_t              ctrl_i,
    hwpe_stream_sink_realign_line_if.slave  push_i,
    hwpe_stream_sink_realign_line_if.master pop_o,
    output logic                            busy_o,
    output logic                            done_o
);
    localparam int OFF_WIDTH = $clog2(STRB_WIDTH);

    realign_line_state_t   state_reg;
    logic [OFF_WIDTH-1:0]  offset_reg;
    logic [LEN_WIDTH-1:0]  cnt_reg;
    logic [LEN_WIDTH-1:0]  beats_reg;
    logic [DATA_WIDTH-1:0] res_data_reg;
    logic [STRB_WIDTH-1:0] res_strb_reg;
    logic                  done_reg;

    logic is_flush, is_last, use_res;
    logic ctrl_hs, push_hs, flush_adv, line_end, beat_done;
    logic [DATA_WIDTH-1:0] sh_new_data, sh_data;
    logic [STRB_WIDTH-1:0] sh_new_strb, sh_strb;

    assign is_flush    = (state_reg == RLN_FLUSH);
    assign is_last     = (cnt_reg == beats_reg - LEN_WIDTH'(1));
    assign use_res     = is_flush || (cnt_reg != '0);
    // The flush beat reuses the shifter with an empty new beat.
    assign sh_new_data = is_flush ? '0 : push_i.data;
    assign sh_new_strb = is_flush ? '0 : push_i.strb;

    assign ctrl_hs = ctrl_valid_i && ctrl_ready_o;
    assign push_hs = push_i.valid && push_i.ready;
    assign busy_o  = (state_reg != RLN_IDLE);
    assign done_o  = done_reg;

    hwpe_stream_sink_realign_line_byte_shift #(
        .DATA_WIDTH (DATA_WIDTH),
        .STRB_WIDTH (STRB_WIDTH)
    ) u_shift (
        .new_data (sh_new_data),
        .new_strb (sh_new_strb),
        .res_data (res_data_reg),
        .res_strb (res_strb_reg),
        .offset   (offset_reg),
        .use_res  (use_res),
        .out_data (sh_data),
        .out_strb (sh_strb)
    );

`ifdef HWPE_STREAM_SINK_REALIGN_SKID_EN
    logic                  out_valid_reg;
    logic                  out_last_reg;
    logic [DATA_WIDTH-1:0] out_data_reg;
    logic [STRB_WIDTH-1:0] out_strb_reg;
    logic                  adv;

    assign adv          = !out_valid_reg || pop_o.ready;
    // A new descriptor waits for the previous line's last beat to leave, so done pulses never merge.
    assign ctrl_ready_o = (state_reg == RLN_IDLE) && !out_valid_reg;
    assign push_i.ready = (state_reg == RLN_STREAM) && adv;
    assign flush_adv    = is_flush && adv;
    assign line_end     = (push_hs && is_last && offset_reg == '0) || flush_adv;
    assign beat_done    = out_valid_reg && out_last_reg && pop_o.ready;
    assign pop_o.valid  = out_valid_reg;
    assign pop_o.data   = out_data_reg;
    assign pop_o.strb   = out_strb_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_data_reg  <= '0;
            out_strb_reg  <= '0;
        end else if (push_hs || flush_adv) begin
            out_valid_reg <= 1'b1;
            out_last_reg  <= line_end;
            out_data_reg  <= sh_data;
            out_strb_reg  <= sh_strb;
        end else if (pop_o.ready) begin
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end
    end
`else
    assign ctrl_ready_o = (state_reg == RLN_IDLE);
    assign push_i.ready = (state_reg == RLN_STREAM) && pop_o.ready;
    assign flush_adv    = is_flush && pop_o.ready;
    assign line_end     = (push_hs && is_last && offset_reg == '0) || flush_adv;
    assign beat_done    = line_end;
    assign pop_o.valid  = (state_reg == RLN_STREAM) ? push_i.valid : is_flush;
    assign pop_o.data   = sh_data;
    assign pop_o.strb   = sh_strb;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_reg    <= RLN_IDLE;
            offset_reg   <= '0;
            cnt_reg      <= '0;
            beats_reg    <= '0;
            res_data_reg <= '0;
            res_strb_reg <= '0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= beat_done || (ctrl_hs && ctrl_i.line_beats == '0);
            case (state_reg)
                RLN_IDLE: begin
                    if (ctrl_hs) begin
                        offset_reg <= OFF_WIDTH'(ctrl_i.offset);
                        beats_reg  <= LEN_WIDTH'(ctrl_i.line_beats);
                        cnt_reg    <= '0;
                        if (ctrl_i.line_beats != '0) begin
                            state_reg <= RLN_STREAM;
                        end
                    end
                end
                RLN_STREAM: begin
                    if (push_hs) begin
                        res_data_reg <= push_i.data;
                        res_strb_reg <= push_i.strb;
                        cnt_reg      <= cnt_reg + LEN_WIDTH'(1);
                        if (is_last) begin
                            state_reg <= (offset_reg == '0) ? RLN_IDLE : RLN_FLUSH;
                        end
                    end
                end
                RLN_FLUSH: begin
                    if (flush_adv) begin
                        state_reg <= RLN_IDLE;
                    end
                end
                default: state_reg <= RLN_IDLE;
            endcase
        end
    end
endmodule
